// File: rtl/infer_pkg.sv
// Shared encodings for the inference sequencer: opcodes, status codes and FSM states.
package infer_pkg;

  typedef logic [1:0] opcode_t;
  localparam opcode_t OP_IDLE  = 2'd0;
  localparam opcode_t OP_WRITE = 2'd1;
  localparam opcode_t OP_RUN   = 2'd2;
  localparam opcode_t OP_ABORT = 2'd3;

  typedef logic [1:0] status_t;
  localparam status_t STAT_IDLE  = 2'd0;
  localparam status_t STAT_BUSY  = 2'd1;
  localparam status_t STAT_VALID = 2'd2;
  localparam status_t STAT_ERROR = 2'd3;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_READ   = 2'd1;
  localparam state_t S_SETTLE = 2'd2;
  localparam state_t S_DONE   = 2'd3;

endpackage

// File: rtl/infer_sequencer_run_slot.sv
// One-deep holding slot for a run request that arrives while the sequencer is busy.
module run_slot
  import infer_pkg::*;
#(
  parameter int TIMER_W = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               clr_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [TIMER_W-1:0] rd_len_i,
  input  logic [TIMER_W-1:0] st_len_i,
  output logic               valid_o,
  output logic [TIMER_W-1:0] rd_len_o,
  output logic [TIMER_W-1:0] st_len_o
);

  logic               valid_q, valid_d;
  logic [TIMER_W-1:0] rd_q, rd_d;
  logic [TIMER_W-1:0] st_q, st_d;

  // A push in the same cycle as a pop refills the slot.
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    st_d    = st_q;
    if (pop_i) valid_d = 1'b0;
    if (push_i) begin
      valid_d = 1'b1;
      rd_d    = rd_len_i;
      st_d    = st_len_i;
    end
    if (clr_i) begin
      valid_d = 1'b0;
      rd_d    = '0;
      st_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      st_q    <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      st_q    <= st_d;
    end
  end

  assign valid_o  = valid_q;
  assign rd_len_o = rd_q;
  assign st_len_o = st_q;

endmodule

// File: rtl/infer_sequencer.sv
// Sequences pattern-memory writes and read/settle/capture runs for the inference aggregator.
//   state  | meaning
//   IDLE   | waiting for a write or run
//   READ   | memory read + counting, read_len cycles
//   SETTLE | counting only, settle_len cycles
//   DONE   | one cycle; aggregator result captured at its end
module infer_sequencer
  import infer_pkg::*;
#(
  parameter int DATA_W  = 19,
  parameter int TIMER_W = 8,
  parameter int RES_W   = 4,
  parameter int ADDR_W  = 7
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        opcode_i,
  input  logic [DATA_W-1:0] data_in,
  output logic              mem_wen_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_ren_o,
  output logic              mem_clr_o,
  output logic              count_en_o,
  input  logic [RES_W-1:0]  result_i,
  input  logic              settled_i,
  output logic [RES_W-1:0]  result_o,
  output logic              result_valid_o,
  input  logic              result_ack_i,
  output logic [1:0]        status_o,
  output logic [ADDR_W:0]   wr_count_o
);

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TIMER_W-1:0] settle_q, settle_d;
  logic               wen_q, wen_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               clr_q;
  logic [RES_W-1:0]   res_q, res_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [ADDR_W:0]    wr_cnt_q, wr_cnt_d;

  logic               run_req, wr_req, abort, wr_ok, capture;
  logic               launch, err_set, slot_push, slot_pop, slot_valid;
  logic [TIMER_W-1:0] run_rd, run_st, slot_rd, slot_st, l_rd, l_st;

  assign run_req = (opcode_i == OP_RUN);
  assign wr_req  = (opcode_i == OP_WRITE);
  assign abort   = (opcode_i == OP_ABORT);
  assign run_rd  = data_in[TIMER_W-1:0];
  assign run_st  = data_in[2*TIMER_W-1:TIMER_W];
  assign wr_ok   = wr_req && (state_q == S_IDLE) && !wr_cnt_q[ADDR_W];
  assign capture = (state_q == S_DONE) && !abort;

  run_slot #(.TIMER_W(TIMER_W)) u_slot (
    .clk      (clk),
    .rstn     (rstn),
    .clr_i    (abort),
    .push_i   (slot_push),
    .pop_i    (slot_pop),
    .rd_len_i (run_rd),
    .st_len_i (run_st),
    .valid_o  (slot_valid),
    .rd_len_o (slot_rd),
    .st_len_o (slot_st)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    settle_d  = settle_q;
    launch    = 1'b0;
    l_rd      = slot_rd;
    l_st      = slot_st;
    slot_pop  = 1'b0;
    slot_push = 1'b0;
    err_set   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (slot_valid) begin
          launch   = 1'b1;
          slot_pop = 1'b1;
        end else if (run_req) begin
          launch = 1'b1;
          l_rd   = run_rd;
          l_st   = run_st;
        end
      end
      S_READ: begin
        if (timer_q > TIMER_W'(1)) timer_d = timer_q - TIMER_W'(1);
        else if (settle_q != '0) begin
          state_d = S_SETTLE;
          timer_d = settle_q;
        end else begin
          state_d = S_DONE;
          timer_d = '0;
        end
      end
      S_SETTLE: begin
        if (timer_q > TIMER_W'(1)) timer_d = timer_q - TIMER_W'(1);
        else begin
          state_d = S_DONE;
          timer_d = '0;
        end
      end
      default: begin
        if (slot_valid) begin
          launch   = 1'b1;
          slot_pop = 1'b1;
        end else state_d = S_IDLE;
      end
    endcase
    // Runs not launched directly go to the slot, or are dropped if it stays full.
    if (run_req && !(state_q == S_IDLE && !slot_valid)) begin
      if (slot_valid && !slot_pop) err_set = 1'b1;
      else slot_push = 1'b1;
    end
    if (launch) begin
      settle_d = l_st;
      if (l_rd != '0) begin
        state_d = S_READ;
        timer_d = l_rd;
      end else if (l_st != '0) begin
        state_d = S_SETTLE;
        timer_d = l_st;
      end else begin
        state_d = S_DONE;
        timer_d = '0;
      end
    end
    if (wr_req && !wr_ok) err_set = 1'b1;
    if (capture && ((valid_q && !result_ack_i) || !settled_i)) err_set = 1'b1;
    wen_d    = wr_ok;
    wdata_d  = wr_ok ? data_in : '0;
    wr_cnt_d = wr_ok ? wr_cnt_q + (ADDR_W+1)'(1) : wr_cnt_q;
    res_d    = capture ? result_i : res_q;
    valid_d  = capture ? 1'b1 : (result_ack_i ? 1'b0 : valid_q);
    err_d    = err_q | err_set;
    if (abort) begin
      state_d   = S_IDLE;
      timer_d   = '0;
      settle_d  = '0;
      slot_push = 1'b0;
      slot_pop  = 1'b0;
      wen_d     = 1'b0;
      wdata_d   = '0;
      wr_cnt_d  = '0;
      valid_d   = 1'b0;
      err_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      settle_q <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      clr_q    <= 1'b0;
      res_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      settle_q <= settle_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      clr_q    <= abort;
      res_q    <= res_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  always_comb begin
    status_o = STAT_IDLE;
    if (err_q) status_o = STAT_ERROR;
    else if (state_q != S_IDLE || slot_valid) status_o = STAT_BUSY;
    else if (valid_q) status_o = STAT_VALID;
  end

  assign mem_wen_o      = wen_q;
  assign mem_wdata_o    = wdata_q;
  assign mem_ren_o      = (state_q == S_READ);
  assign mem_clr_o      = clr_q;
  assign count_en_o     = (state_q == S_READ) || (state_q == S_SETTLE);
  assign result_o       = res_q;
  assign result_valid_o = valid_q;
  assign wr_count_o     = wr_cnt_q;

endmodule

// File: tb/tb_infer_sequencer.sv
// Directed bench for infer_sequencer with hand-computed expectations.
module tb_infer_sequencer;
  import infer_pkg::*;

  localparam int DATA_W  = 19;
  localparam int TIMER_W = 8;
  localparam int RES_W   = 4;
  localparam int ADDR_W  = 7;

  logic              clk = 1'b0;
  logic              rstn;
  logic [1:0]        opcode_i;
  logic [DATA_W-1:0] data_in;
  logic              mem_wen_o, mem_ren_o, mem_clr_o, count_en_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [RES_W-1:0]  result_i, result_o;
  logic              settled_i, result_valid_o, result_ack_i;
  logic [1:0]        status_o;
  logic [ADDR_W:0]   wr_count_o;

  int n_total = 0;
  int n_bad   = 0;

  infer_sequencer #(
    .DATA_W(DATA_W), .TIMER_W(TIMER_W), .RES_W(RES_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .opcode_i       (opcode_i),
    .data_in        (data_in),
    .mem_wen_o      (mem_wen_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_ren_o      (mem_ren_o),
    .mem_clr_o      (mem_clr_o),
    .count_en_o     (count_en_o),
    .result_i       (result_i),
    .settled_i      (settled_i),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .result_ack_i   (result_ack_i),
    .status_o       (status_o),
    .wr_count_o     (wr_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] mk_run(input int rd, input int st);
    logic [DATA_W-1:0] v;
    v = '0;
    v[TIMER_W-1:0]         = rd[TIMER_W-1:0];
    v[2*TIMER_W-1:TIMER_W] = st[TIMER_W-1:0];
    return v;
  endfunction

  logic [DATA_W-1:0] wvals [3];
  logic [14:1]       ren_bits, cen_bits;
  int                ren_n, cen_n, first_valid;

  initial begin
    rstn = 1'b0; opcode_i = OP_IDLE; data_in = '0;
    result_i = 4'hA; settled_i = 1'b1; result_ack_i = 1'b0;
    wvals[0] = 19'h12345; wvals[1] = 19'h7FFFF; wvals[2] = 19'h00001;
    #1;
    chk("rst_status", status_o, 0);
    chk("rst_wrcnt", wr_count_o, 0);
    chk("rst_valid", result_valid_o, 0);
    chk("rst_outs", {mem_wen_o, mem_ren_o, mem_clr_o, count_en_o}, 0);
    tick(); tick();
    rstn = 1'b1;

    // three writes in IDLE
    for (int i = 0; i < 3; i++) begin
      opcode_i = OP_WRITE; data_in = wvals[i];
      tick();
      chk("wr_wen", mem_wen_o, 1);
      chk("wr_wdata", mem_wdata_o, wvals[i]);
      chk("wr_cnt", wr_count_o, i + 1);
    end
    opcode_i = OP_IDLE; data_in = '0;
    tick();
    chk("wr_wen_off", mem_wen_o, 0);
    chk("wr_wdata_zero", mem_wdata_o, 0);
    chk("wr_cnt3", wr_count_o, 3);
    chk("wr_status", status_o, 0);

    // run read=5 settle=3
    opcode_i = OP_RUN; data_in = mk_run(5, 3);
    tick();
    opcode_i = OP_IDLE; data_in = '0;
    ren_n = 0; cen_n = 0; first_valid = -1;
    for (int i = 0; i < 12; i++) begin
      ren_n += int'(mem_ren_o);
      cen_n += int'(count_en_o);
      if (result_valid_o && first_valid < 0) first_valid = i;
      tick();
    end
    chk("run53_ren", ren_n, 5);
    chk("run53_cen", cen_n, 8);
    chk("run53_first_valid", first_valid, 9);
    chk("run53_valid", result_valid_o, 1);
    chk("run53_result", result_o, 4'hA);
    chk("run53_status", status_o, 2);
    result_ack_i = 1'b1;
    tick();
    result_ack_i = 1'b0;
    chk("ack_valid", result_valid_o, 0);
    chk("ack_status", status_o, 0);

    // run read=0 settle=0
    result_i = 4'h3;
    opcode_i = OP_RUN; data_in = mk_run(0, 0);
    tick();
    opcode_i = OP_IDLE; data_in = '0;
    chk("run00_busy", status_o, 1);
    chk("run00_valid_early", result_valid_o, 0);
    tick();
    chk("run00_valid", result_valid_o, 1);
    chk("run00_result", result_o, 4'h3);
    result_ack_i = 1'b1;
    tick();
    result_ack_i = 1'b0;

    // capture with settled_i low still stores but flags error
    settled_i = 1'b0; result_i = 4'h6;
    opcode_i = OP_RUN; data_in = mk_run(0, 0);
    tick();
    opcode_i = OP_IDLE; data_in = '0;
    tick();
    settled_i = 1'b1;
    chk("unsettled_result", result_o, 4'h6);
    chk("unsettled_err", status_o, 3);
    opcode_i = OP_ABORT;
    tick();
    opcode_i = OP_IDLE;
    chk("abort1_clr", mem_clr_o, 1);
    chk("abort1_status", status_o, 0);
    chk("abort1_valid", result_valid_o, 0);
    chk("abort1_wrcnt", wr_count_o, 0);
    tick();
    chk("abort1_clr_off", mem_clr_o, 0);

    // run(4,2), run(1,1) during READ, third run during SETTLE
    result_i = 4'h5;
    for (int i = 1; i <= 14; i++) begin
      opcode_i = OP_IDLE; data_in = '0;
      if (i == 1) begin opcode_i = OP_RUN; data_in = mk_run(4, 2); end
      if (i == 2) begin opcode_i = OP_RUN; data_in = mk_run(1, 1); end
      if (i == 6) begin opcode_i = OP_RUN; data_in = mk_run(9, 9); end
      tick();
      ren_bits[i] = mem_ren_o;
      cen_bits[i] = count_en_o;
      if (i == 6) chk("pend_drop_err", status_o, 3);
    end
    opcode_i = OP_IDLE; data_in = '0;
    chk("pend_ren_pattern", ren_bits, 14'b000000_1_000_1111);
    chk("pend_cen_pattern", cen_bits, 14'b00000_11_0_111111);
    chk("pend_valid", result_valid_o, 1);
    chk("pend_result", result_o, 4'h5);

    // reset during SETTLE
    result_i = 4'h9;
    opcode_i = OP_RUN; data_in = mk_run(2, 5);
    tick();
    opcode_i = OP_IDLE; data_in = '0;
    tick(); tick();
    chk("rstmid_settle", {mem_ren_o, count_en_o}, 2'b01);
    rstn = 1'b0;
    #1;
    chk("rstmid_cen", count_en_o, 0);
    chk("rstmid_status", status_o, 0);
    chk("rstmid_result", result_o, 0);
    chk("rstmid_valid", result_valid_o, 0);
    tick(); tick();
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("rstrel_valid", result_valid_o, 0);
    chk("rstrel_result", result_o, 0);
    chk("rstrel_status", status_o, 0);

    // fill memory, one extra write rejected, then abort
    for (int i = 0; i <= 128; i++) begin
      opcode_i = OP_WRITE; data_in = DATA_W'(i + 1);
      tick();
      if (i == 127) chk("fill_last_ok", {mem_wen_o, wr_count_o}, {1'b1, 8'd128});
      if (i == 128) chk("fill_reject_wen", mem_wen_o, 0);
    end
    opcode_i = OP_IDLE; data_in = '0;
    chk("fill_wrcnt", wr_count_o, 128);
    chk("fill_err", status_o, 3);
    tick();
    opcode_i = OP_ABORT;
    tick();
    opcode_i = OP_IDLE;
    chk("abort2_clr", mem_clr_o, 1);
    chk("abort2_wrcnt", wr_count_o, 0);
    chk("abort2_status", status_o, 0);
    tick();
    chk("abort2_clr_off", mem_clr_o, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
